icache_fill_fsm: RTL and testbench

- Cache-miss fill controller between the fetch stage (upstream of the PC/decode datapath) and multi-cycle main memory.
- On a miss it fetches one 16-byte block (8 × 16-bit words) with pipelined reads, one request per cycle.
- It writes each returned word into the cache data array, then writes the tag.
- The fetch stage stalls on fsm_busy.

---
 rtl/icache_fill_fsm_if.sv | 31 +++
 rtl/icache_fill_fsm.sv | 110 +++++++++++
 tb/tb_icache_fill_fsm.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fill_fsm_if.sv
// Bus between the instruction-cache fill controller, the fetch stage, main memory and the cache arrays.
// The slave modport is the controller's view; master is the surrounding system's view.
interface icache_fill_fsm_if #(
    parameter int WORDS_PER_BLOCK = 8
);
    localparam int WORD_IDX_W = $clog2(WORDS_PER_BLOCK);

    logic                  miss_detected;
    logic [15:0]           miss_address;
    logic                  fsm_busy;
    logic                  mem_read;
    logic [15:0]           memory_address;
    logic [15:0]           memory_data;
    logic                  memory_data_valid;
    logic                  write_data_array;
    logic [WORD_IDX_W-1:0] fill_word;
    logic [15:0]           fill_data;
    logic                  write_tag_array;

    modport slave (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output fsm_busy, mem_read, memory_address,
        output write_data_array, fill_word, fill_data, write_tag_array
    );

    modport master (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  fsm_busy, mem_read, memory_address,
        input  write_data_array, fill_word, fill_data, write_tag_array
    );
endinterface

// File: rtl/icache_fill_fsm.sv
// Instruction-cache miss fill controller: issues one pipelined read per cycle for a whole block,
// writes each returned word into the data array and writes the tag together with the last word.
module icache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    icache_fill_fsm_if.slave  bus
);
    localparam int ADDR_W   = 16;
    localparam int IDX_W    = $clog2(WORDS_PER_BLOCK);
    localparam int ISSUE_W  = IDX_W + 1;
    localparam int OFS_W    = IDX_W + 1;

    localparam logic [ISSUE_W-1:0] ISSUE_LAST = ISSUE_W'(WORDS_PER_BLOCK - 1);
    localparam logic [IDX_W-1:0]   RECV_LAST  = IDX_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_W-1:0]  OFS_MASK   = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic [0:0] {
        IDLE,
        FILL
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ISSUE_W-1:0]  issue_cnt_q;
    logic [IDX_W-1:0]    recv_cnt_q;
    logic                mem_read_q;
    logic [ADDR_W-1:0]   mem_addr_q;

    logic [ADDR_W-1:0]   base_d;
    logic [ISSUE_W-1:0]  issue_nxt;
    logic [ADDR_W-1:0]   next_ofs;

    assign base_d    = bus.miss_address & ~OFS_MASK;
    assign issue_nxt = issue_cnt_q + 1'b1;
    assign next_ofs  = ADDR_W'({issue_nxt, 1'b0});

    // The request address is registered: it is prepared one cycle ahead so it
    // lines up with mem_read_q, and it simply holds once the last read has gone out.
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.miss_detected) begin
                        state_q     <= FILL;
                        base_q      <= base_d;
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= base_d;
                    end
                end
                FILL: begin
                    if (mem_read_q) begin
                        issue_cnt_q <= issue_nxt;
                        if (issue_cnt_q == ISSUE_LAST) begin
                            mem_read_q <= 1'b0;
                        end else begin
                            mem_addr_q <= base_q + next_ofs;
                        end
                    end
                    // Receive side runs independently of issue; the last word ends the fill.
                    if (bus.memory_data_valid) begin
                        recv_cnt_q <= recv_cnt_q + 1'b1;
                        if (recv_cnt_q == RECV_LAST) begin
                            state_q    <= IDLE;
                            mem_read_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fsm_busy       = (state_q == FILL);
    assign bus.mem_read       = mem_read_q;
    assign bus.memory_address = mem_addr_q;

    // Array writes follow memory_data_valid in the same cycle, so they stay combinational.
    // NOTE: each output gets a default before the if, so no path leaves it unassigned (no latch).
    always_comb begin
        bus.write_data_array = 1'b0;
        bus.fill_word        = '0;
        bus.fill_data        = '0;
        bus.write_tag_array  = 1'b0;
        if (state_q == FILL && bus.memory_data_valid) begin
            bus.write_data_array = 1'b1;
            bus.fill_word        = recv_cnt_q;
            bus.fill_data        = bus.memory_data;
            bus.write_tag_array  = (recv_cnt_q == RECV_LAST);
        end
    end

    a_tag_with_data: assert property (@(posedge clk) disable iff (!rst_n)
        bus.write_tag_array |-> bus.write_data_array);

    a_read_in_block: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_read |-> (bus.memory_address[ADDR_W-1:OFS_W] == base_q[ADDR_W-1:OFS_W]));

endmodule

// File: tb/tb_icache_fill_fsm.sv
// Testbench for icache_fill_fsm: a cycle table for one fixed-latency fill, then directed and random
// fills checked against a transaction-level model of the fill rules and a pipelined memory.
module tb_icache_fill_fsm;
    localparam int W           = 8;
    localparam int MEM_LATENCY = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    icache_fill_fsm_if #(.WORDS_PER_BLOCK(W)) bus ();
    icache_fill_fsm #(.WORDS_PER_BLOCK(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word stored at each byte address of the simulated main memory.
    function automatic logic [15:0] data_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // ---------------- memory model: in-order pipelined reads ----------------
    typedef struct { logic [15:0] addr; int due; } req_t;
    req_t pend[$];
    int   cyc      = 0;
    int   last_due = 0;

    // ---------------- fill model: one block = W consecutive word reads ----------------
    bit          m_busy = 1'b0;
    logic [15:0] m_base = '0;
    logic [15:0] m_req[$];
    int          m_rx = 0;
    int          fills_done = 0;

    // Stimulus knobs and the inputs presented in the current cycle.
    bit          k_miss = 1'b0, k_rand_miss = 1'b0, k_stray = 1'b0;
    logic [15:0] k_addr = '0;
    int          k_vld_pct = 100, k_lat_min = MEM_LATENCY, k_lat_max = MEM_LATENCY;
    bit          cur_miss, cur_vld;
    logic [15:0] cur_addr, cur_data;

    // Observations of the DUT itself.
    int          tags_seen = 0;
    int          writes_seen = 0;
    logic [15:0] dut_reqs[$];

    // NOTE: inputs are driven with blocking assignments just after the clock edge.
    task automatic drive_inputs();
        cur_miss = k_rand_miss ? ($urandom_range(99) < 30) : k_miss;
        cur_addr = k_rand_miss ? 16'($urandom) : k_addr;
        cur_vld  = 1'b0;
        cur_data = 16'($urandom);
        if (pend.size() > 0) begin
            if (pend[0].due <= cyc && $urandom_range(99) < k_vld_pct) begin
                cur_vld  = 1'b1;
                cur_data = data_of(pend[0].addr);
                void'(pend.pop_front());
            end
        end else if (k_stray && !m_busy && $urandom_range(99) < 20) begin
            cur_vld = 1'b1;
        end
        bus.miss_detected     = cur_miss;
        bus.miss_address      = cur_addr;
        bus.memory_data_valid = cur_vld;
        bus.memory_data       = cur_data;
    endtask

    task automatic check_outputs();
        bit e_rd;
        bit e_wr;
        e_rd = m_busy && (m_req.size() > 0);
        e_wr = m_busy && cur_vld;
        check("fsm_busy", 16'(bus.fsm_busy), 16'(m_busy));
        check("mem_read", 16'(bus.mem_read), 16'(e_rd));
        if (e_rd) check("memory_address", bus.memory_address, m_req[0]);
        check("write_data_array", 16'(bus.write_data_array), 16'(e_wr));
        if (e_wr) begin
            check("fill_word", 16'(bus.fill_word), 16'(m_rx));
            check("fill_data", bus.fill_data, data_of(m_base + 16'(2 * m_rx)));
        end else begin
            check("fill_data idle", bus.fill_data, 16'h0000);
        end
        check("write_tag_array", 16'(bus.write_tag_array), 16'(e_wr && m_rx == W - 1));
        if (bus.write_tag_array === 1'b1) tags_seen++;
        if (bus.write_data_array === 1'b1) writes_seen++;
        if (bus.mem_read === 1'b1) dut_reqs.push_back(bus.memory_address);
    endtask

    task automatic model_update();
        if (!m_busy) begin
            if (cur_miss) begin
                m_busy = 1'b1;
                m_base = cur_addr & ~16'(2 * W - 1);
                m_rx   = 0;
                m_req.delete();
                for (int k = 0; k < W; k++) m_req.push_back(m_base + 16'(2 * k));
            end
        end else begin
            if (m_req.size() > 0) begin
                int due;
                due = cyc + int'($urandom_range(k_lat_max, k_lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: m_req.pop_front(), due: due});
            end
            if (cur_vld) begin
                m_rx++;
                if (m_rx == W) begin
                    m_busy = 1'b0;
                    fills_done++;
                end
            end
        end
        cyc++;
    endtask

    // One clock cycle; entered and left just after a rising edge.
    task automatic cycle();
        drive_inputs();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_fills(input int target, input int budget);
        int n;
        n = 0;
        while (fills_done < target && n < budget) begin
            cycle();
            n++;
        end
        check("fill completes within budget", 16'(fills_done >= target), 16'h0001);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        k_miss = 1'b0;
        k_rand_miss = 1'b0;
        while ((m_busy || pend.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain within budget", 16'(!m_busy && pend.size() == 0), 16'h0001);
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, " fsm_busy"}, 16'(bus.fsm_busy), 16'h0);
        check({tag, " mem_read"}, 16'(bus.mem_read), 16'h0);
        check({tag, " memory_address"}, bus.memory_address, 16'h0000);
        check({tag, " write_data_array"}, 16'(bus.write_data_array), 16'h0);
        check({tag, " fill_word"}, 16'(bus.fill_word), 16'h0);
        check({tag, " fill_data"}, bus.fill_data, 16'h0000);
        check({tag, " write_tag_array"}, 16'(bus.write_tag_array), 16'h0);
    endtask

    // Cycle-by-cycle vectors for a miss at 0x1236 with memory latency 4.
    typedef struct {
        bit          miss;
        logic [15:0] addr;
        bit          vld;
        logic [15:0] data;
        bit          busy;
        bit          rd;
        logic [15:0] maddr;
        bit          wr;
        logic [2:0]  word;
        bit          tag;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, w0, t0, n;

        //           miss  addr     vld   data      busy  rd    maddr     wr    word  tag
        vecs[0]  = '{1'b1, 16'h1236, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 1'b0};
        vecs[2]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 1'b0};
        vecs[3]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0};
        vecs[4]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 1'b0};
        vecs[5]  = '{1'b0, 16'h1236, 1'b1, 16'hD000, 1'b1, 1'b1, 16'h1238, 1'b1, 3'd0, 1'b0};
        vecs[6]  = '{1'b0, 16'h1236, 1'b1, 16'hD001, 1'b1, 1'b1, 16'h123A, 1'b1, 3'd1, 1'b0};
        vecs[7]  = '{1'b0, 16'h1236, 1'b1, 16'hD002, 1'b1, 1'b1, 16'h123C, 1'b1, 3'd2, 1'b0};
        vecs[8]  = '{1'b0, 16'h1236, 1'b1, 16'hD003, 1'b1, 1'b1, 16'h123E, 1'b1, 3'd3, 1'b0};
        vecs[9]  = '{1'b0, 16'h1236, 1'b1, 16'hD004, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b0};
        vecs[10] = '{1'b0, 16'h1236, 1'b1, 16'hD005, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0};
        vecs[11] = '{1'b0, 16'h1236, 1'b1, 16'hD006, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 1'b0};
        vecs[12] = '{1'b0, 16'h1236, 1'b1, 16'hD007, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 1'b1};
        vecs[13] = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};
        vecs[14] = '{1'b0, 16'h1236, 1'b1, 16'hD0FF, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};

        bus.miss_detected     = 1'b0;
        bus.miss_address      = 16'h0000;
        bus.memory_data       = 16'h0000;
        bus.memory_data_valid = 1'b0;

        // Asynchronous reset asserted between clock edges.
        #2 rst_n = 1'b0;
        #1 check_reset_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fixed-latency fill, checked cycle by cycle from the table.
        for (int i = 0; i < 15; i++) begin
            bus.miss_detected     = vecs[i].miss;
            bus.miss_address      = vecs[i].addr;
            bus.memory_data_valid = vecs[i].vld;
            bus.memory_data       = vecs[i].data;
            @(negedge clk);
            check($sformatf("tbl[%0d] fsm_busy", i), 16'(bus.fsm_busy), 16'(vecs[i].busy));
            check($sformatf("tbl[%0d] mem_read", i), 16'(bus.mem_read), 16'(vecs[i].rd));
            if (vecs[i].rd) check($sformatf("tbl[%0d] memory_address", i), bus.memory_address, vecs[i].maddr);
            check($sformatf("tbl[%0d] write_data_array", i), 16'(bus.write_data_array), 16'(vecs[i].wr));
            if (vecs[i].wr) check($sformatf("tbl[%0d] fill_word", i), 16'(bus.fill_word), 16'(vecs[i].word));
            check($sformatf("tbl[%0d] fill_data", i), bus.fill_data, vecs[i].wr ? vecs[i].data : 16'h0000);
            check($sformatf("tbl[%0d] write_tag_array", i), 16'(bus.write_tag_array), 16'(vecs[i].tag));
            @(posedge clk);
            #1;
        end

        // Irregular valid gaps stretch the fill; exactly one block of writes still lands.
        f0 = fills_done;
        w0 = writes_seen;
        k_addr = 16'h2A5C;
        k_miss = 1'b1;
        cycle();
        k_miss = 1'b0;
        k_vld_pct = 35;
        run_fills(f0 + 1, 300);
        check("gap fill data writes", 16'(writes_seen - w0), 16'd8);
        cycle();
        k_vld_pct = 100;

        // Miss held through the fill with a changing address: base is latched, refill is back-to-back.
        f0 = fills_done;
        dut_reqs.delete();
        k_addr = 16'h0040;
        k_miss = 1'b1;
        repeat (5) cycle();
        k_addr = 16'h0080;
        run_fills(f0 + 2, 200);
        drain(50);
        check("b2b request count", 16'(dut_reqs.size()), 16'd16);
        if (dut_reqs.size() >= 16) begin
            check("b2b first req", dut_reqs[0], 16'h0040);
            check("b2b last req of fill 1", dut_reqs[7], 16'h004E);
            check("b2b first req of fill 2", dut_reqs[8], 16'h0080);
            check("b2b last req of fill 2", dut_reqs[15], 16'h008E);
        end

        // Reset after three words: everything drops at once and late returns are ignored.
        k_addr = 16'h3370;
        k_miss = 1'b1;
        cycle();
        k_miss = 1'b0;
        n = 0;
        while (m_rx < 3 && n < 100) begin
            cycle();
            n++;
        end
        check("words before reset", 16'(m_rx), 16'd3);
        t0 = tags_seen;
        w0 = writes_seen;
        drive_inputs();
        #2 rst_n = 1'b0;
        #1 check_reset_zero("mid-fill reset");
        m_busy = 1'b0;
        m_rx   = 0;
        m_req.delete();
        @(posedge clk);
        cyc++;
        #1 rst_n = 1'b1;
        drain(100);
        check("no tag after reset", 16'(tags_seen - t0), 16'd0);
        check("no writes from stale valids", 16'(writes_seen - w0), 16'd0);

        // Block at the top of the address space stays inside the block.
        f0 = fills_done;
        dut_reqs.delete();
        k_addr = 16'hFFF8;
        k_miss = 1'b1;
        cycle();
        k_miss = 1'b0;
        run_fills(f0 + 1, 100);
        check("top block request count", 16'(dut_reqs.size()), 16'd8);
        if (dut_reqs.size() >= 8) begin
            check("top block first req", dut_reqs[0], 16'hFFF0);
            check("top block last req", dut_reqs[7], 16'hFFFE);
        end

        // Random misses, latencies, valid gaps and stray idle valids.
        k_rand_miss = 1'b1;
        k_stray     = 1'b1;
        k_vld_pct   = 70;
        k_lat_min   = 1;
        k_lat_max   = 6;
        repeat (2000) cycle();
        k_stray = 1'b0;
        drain(300);
        check("one tag per completed fill", 16'(tags_seen), 16'(fills_done));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
